// File: rtl/rv32m_muldiv_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
interface rv32m_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, funct3, a, b, flush,
        input  ready, done, result
    );

    modport slave (
        input  start, funct3, a, b, flush,
        output ready, done, result
    );
endinterface

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide,
// one bit per cycle, sharing a single 2*WIDTH accumulator.
module rv32m_muldiv #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input logic          clk,
    input logic          rst,
    rv32m_muldiv_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic               ready;
    logic               done;
    logic [WIDTH-1:0]   result;

    assign bus.ready  = ready;
    assign bus.done   = done;
    assign bus.result = result;

    logic             is_signed_a, is_signed_b, neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             div_zero, div_ovf;

    always_comb begin
        is_signed_a = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                      (bus.funct3[2] && !bus.funct3[0]);
        is_signed_b = (bus.funct3 == 3'b001) || (bus.funct3[2] && !bus.funct3[0]);
        neg_a       = is_signed_a && bus.a[WIDTH-1];
        neg_b       = is_signed_b && bus.b[WIDTH-1];
        mag_a       = neg_a ? -bus.a : bus.a;
        mag_b       = neg_b ? -bus.b : bus.b;
        div_zero    = bus.funct3[2] && (bus.b == '0);
        div_ovf     = bus.funct3[2] && !bus.funct3[0] && (bus.a == MinVal) && (bus.b == '1);
    end

    // Upper half holds partial product / partial remainder, lower half the
    // multiplier / dividend being shifted out.
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum, shifted, diff;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt, acc_nxt, prod_fix;
    logic [WIDTH-1:0]   quo, rmd, fix_result;

    always_comb begin
        addend  = acc[0] ? opnd : {WIDTH{1'b0}};
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        mul_nxt = {sum, acc[WIDTH-1:1]};
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        if (!diff[WIDTH]) begin
            div_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
        acc_nxt  = op[2] ? div_nxt : mul_nxt;
        prod_fix = (sign_a ^ sign_b) ? -acc_nxt : acc_nxt;
        quo      = (sign_a ^ sign_b) ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
        rmd      = sign_a ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
        case (op)
            3'b000:                 fix_result = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_result = quo;
            default:                fix_result = rmd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            cnt    <= '0;
            op     <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            ready  <= 1'b1;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (bus.start && !bus.flush) begin
                        ready <= 1'b0;
                        op    <= bus.funct3;
                        if (div_zero) begin
                            state  <= StDone;
                            done   <= 1'b1;
                            result <= bus.funct3[1] ? bus.a : {WIDTH{1'b1}};
                        end else if (div_ovf) begin
                            state  <= StDone;
                            done   <= 1'b1;
                            result <= bus.funct3[1] ? {WIDTH{1'b0}} : bus.a;
                        end else begin
                            state  <= StCalc;
                            cnt    <= '0;
                            sign_a <= neg_a;
                            sign_b <= neg_b;
                            opnd   <= bus.funct3[2] ? mag_b : mag_a;
                            acc    <= {{WIDTH{1'b0}}, (bus.funct3[2] ? mag_a : mag_b)};
                        end
                    end
                end
                StCalc: begin
                    if (bus.flush) begin
                        state <= StIdle;
                        ready <= 1'b1;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state  <= StDone;
                            done   <= 1'b1;
                            result <= fix_result;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
